// File: rtl/instr_fetch_unit.sv
// LEGv8 multi-cycle instruction fetch stage: PC register, handshaked imem fetch,
// instruction latch and next-PC selection on commit, plus a retired-instruction counter.
module instr_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        CLK,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_data,
    output logic [31:0] instr,
    output logic [10:0] opcode,
    output logic        instr_valid,
    output logic [63:0] currentpc,
    input  logic        commit,
    input  logic        branch,
    input  logic        uncond_branch,
    input  logic        zero,
    input  logic [63:0] branch_offset,
    output logic [31:0] retired
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [1:0]  r_state;
    logic [63:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_retired;

    logic        w_taken;
    logic [63:0] w_next_pc;
    logic        w_req;
    logic        w_valid;

    // Next-PC select; the word offset is shifted left by two, dropping its top two bits.
    always_comb begin
        w_taken   = uncond_branch | (branch & zero);
        w_next_pc = r_pc + 64'd4;
        if (w_taken) begin
            w_next_pc = r_pc + {branch_offset[61:0], 2'b00};
        end else begin
            w_next_pc = r_pc + 64'd4;
        end
    end

    // Handshake strobes are pure state decodes, so they are mutually exclusive.
    always_comb begin
        w_req   = 1'b0;
        w_valid = 1'b0;
        case (r_state)
            FETCH:   w_req   = 1'b1;
            HOLD:    w_valid = 1'b1;
            default: begin
                w_req   = 1'b0;
                w_valid = 1'b0;
            end
        endcase
    end

    // Fetch FSM with PC, instruction latch and retire counter.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_pc      <= RESET_PC;
            r_instr   <= 32'h0;
            r_retired <= 32'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= FETCH;
                end
                FETCH: begin
                    if (imem_ready) begin
                        r_instr <= imem_data;
                        r_state <= HOLD;
                    end else begin
                        r_state <= FETCH;
                    end
                end
                HOLD: begin
                    if (commit) begin
                        r_pc      <= w_next_pc;
                        r_retired <= r_retired + 32'd1;
                        r_state   <= FETCH;
                    end else begin
                        r_state <= HOLD;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign imem_req    = w_req;
    assign instr_valid = w_valid;
    assign imem_addr   = r_pc;
    assign currentpc   = r_pc;
    assign instr       = r_instr;
    assign opcode      = r_instr[31:21];
    assign retired     = r_retired;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit with hand-computed expectations.
module tb_instr_fetch_unit;

    logic        CLK;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic [10:0] opcode;
    logic        instr_valid;
    logic [63:0] currentpc;
    logic        commit;
    logic        branch;
    logic        uncond_branch;
    logic        zero;
    logic [63:0] branch_offset;
    logic [31:0] retired;

    int checks_r = 0;
    int errors_r = 0;

    instr_fetch_unit #(.RESET_PC(64'h100)) dut (
        .CLK           (CLK),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_data     (imem_data),
        .instr         (instr),
        .opcode        (opcode),
        .instr_valid   (instr_valid),
        .currentpc     (currentpc),
        .commit        (commit),
        .branch        (branch),
        .uncond_branch (uncond_branch),
        .zero          (zero),
        .branch_offset (branch_offset),
        .retired       (retired)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks_r++;
        if (act !== exp) begin
            errors_r++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    // Present one instruction word for a single edge; the FSM must be in FETCH.
    task automatic do_fetch(input logic [31:0] data, input logic [10:0] exp_op);
        imem_ready = 1'b1;
        imem_data  = data;
        @(posedge CLK); #1;
        imem_ready = 1'b0;
        imem_data  = 32'hDEAD_BEEF;
        check_val("fetch_valid", {63'd0, instr_valid}, 64'd1);
        check_val("fetch_req",   {63'd0, imem_req},    64'd0);
        check_val("fetch_instr", {32'd0, instr},       {32'd0, data});
        check_val("fetch_op",    {53'd0, opcode},      {53'd0, exp_op});
    endtask

    task automatic do_commit(input logic br, input logic ub, input logic z,
                             input logic [63:0] off, input logic [63:0] exp_pc,
                             input logic [31:0] exp_ret);
        commit        = 1'b1;
        branch        = br;
        uncond_branch = ub;
        zero          = z;
        branch_offset = off;
        @(posedge CLK); #1;
        commit        = 1'b0;
        branch        = 1'b0;
        uncond_branch = 1'b0;
        zero          = 1'b0;
        branch_offset = 64'h0;
        check_val("commit_pc",  imem_addr,            exp_pc);
        check_val("commit_req", {63'd0, imem_req},    64'd1);
        check_val("commit_ret", {32'd0, retired},     {32'd0, exp_ret});
    endtask

    initial begin
        reset         = 1'b1;
        imem_ready    = 1'b0;
        imem_data     = 32'h0;
        commit        = 1'b0;
        branch        = 1'b0;
        uncond_branch = 1'b0;
        zero          = 1'b0;
        branch_offset = 64'h0;
        repeat (2) @(posedge CLK);
        #1;
        check_val("rst_pc",    currentpc,              64'h100);
        check_val("rst_req",   {63'd0, imem_req},      64'd0);
        check_val("rst_valid", {63'd0, instr_valid},   64'd0);
        check_val("rst_ret",   {32'd0, retired},       64'd0);
        check_val("rst_instr", {32'd0, instr},         64'd0);
        reset = 1'b0;
        @(posedge CLK); #1;
        check_val("idle_req",  {63'd0, imem_req},      64'd1);
        check_val("idle_addr", imem_addr,              64'h100);

        // Sequential ADD; commit with imem_ready also high must not reload instr.
        do_fetch(32'h8B02_0020, 11'h458);
        imem_ready = 1'b1;
        imem_data  = 32'h1234_5678;
        do_commit(1'b0, 1'b0, 1'b0, 64'h0, 64'h104, 32'd1);
        imem_ready = 1'b0;
        check_val("both_instr", {32'd0, instr},  64'h8B02_0020);
        check_val("op_invalid", {53'd0, opcode}, 64'h458);

        // Jump 0x104 -> 0x200, then CBZ taken with offset -2.
        do_fetch(32'h1400_003F, 11'h0A0);
        do_commit(1'b0, 1'b1, 1'b0, 64'h3F, 64'h200, 32'd2);
        do_fetch(32'hB4FF_FFC0, 11'h5A7);
        do_commit(1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h1F8, 32'd3);

        // Back to 0x200 with CBZ taken +2, then CBZ not taken.
        do_fetch(32'hB400_0040, 11'h5A0);
        do_commit(1'b1, 1'b0, 1'b1, 64'h2, 64'h200, 32'd4);
        do_fetch(32'hB4FF_FFC0, 11'h5A7);
        do_commit(1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h204, 32'd5);

        // B to 0 (offset -0x81), then B +0x10 with branch=1, zero=0.
        do_fetch(32'h17FF_FF7F, 11'h0BF);
        do_commit(1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FF7F, 64'h0, 32'd6);
        do_fetch(32'h1400_0010, 11'h0A0);
        do_commit(1'b1, 1'b1, 1'b0, 64'h10, 64'h40, 32'd7);

        // Memory wait states with a stray commit pulse.
        commit = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            check_val("wait_req",   {63'd0, imem_req},    64'd1);
            check_val("wait_valid", {63'd0, instr_valid}, 64'd0);
        end
        commit = 1'b0;
        check_val("wait_pc",  imem_addr,        64'h40);
        check_val("wait_ret", {32'd0, retired}, 64'd7);

        // PC wrap: jump to 0x...FFFC, then sequential commit wraps to 0.
        do_fetch(32'h17FF_FFEF, 11'h0BF);
        do_commit(1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFEF, 64'hFFFF_FFFF_FFFF_FFFC, 32'd8);
        do_fetch(32'h8B02_0020, 11'h458);
        do_commit(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 32'd9);

        // Offset bits 63:62 are shifted out.
        do_fetch(32'h1400_0001, 11'h0A0);
        do_commit(1'b0, 1'b1, 1'b0, 64'hC000_0000_0000_0001, 64'h4, 32'd10);

        // Reset in HOLD drops the instruction immediately.
        do_fetch(32'hF840_0000, 11'h7C2);
        #2;
        reset = 1'b1;
        #1;
        check_val("mrst_valid", {63'd0, instr_valid}, 64'd0);
        check_val("mrst_pc",    currentpc,            64'h100);
        check_val("mrst_ret",   {32'd0, retired},     64'd0);
        check_val("mrst_req",   {63'd0, imem_req},    64'd0);
        @(posedge CLK); #1;
        reset = 1'b0;
        @(posedge CLK); #1;
        check_val("post_req",  {63'd0, imem_req}, 64'd1);
        check_val("post_addr", imem_addr,         64'h100);

        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

endmodule
